dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter and access sequencer in front of the single-ported data memory. It shares the memory between the pipeline MEM stage (port 0) and a secondary master such as a loader or debug port (port 1). It latches one request at a time, drives the memory's read/write strobes for a fixed access window, captures read data and returns a one-cycle completion pulse to the owning requester. Misaligned word accesses are rejected without touching memory.

## Interface
Parameters:
- `AW`, 32: address width (byte address).
- `DW`, 32: data width.
- `LAT`, 2: memory access window in cycles (≥1). Strobes are held for this many cycles and `mem_rdata` is sampled on the last one.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `pN_req`, input, 1 (N=0,1): request. Held high until `pN_done` is seen.
- `pN_we`, input, 1: 1 = write, 0 = read.
- `pN_addr`, input, AW: byte address.
- `pN_wdata`, input, DW: write data.
- `pN_done`, output, 1: one-cycle completion pulse.
- `pN_rdata`, output, DW: read data, valid while `pN_done` is high.
- `pN_err`, output, 1: misaligned address flag, valid with `pN_done`.
- `mem_addr`, output, AW: byte address to memory (memory indexes words as `addr>>2`).
- `mem_wdata`, output, DW: write data to memory.
- `mem_read`, output, 1: read strobe.
- `mem_write`, output, 1: write strobe.
- `mem_rdata`, input, DW: memory read data.

## Operation
- State machine states:
  - IDLE: samples requests.
  - ACCESS: counts `LAT` cycles with strobes driven.
  - DONE: one cycle; pulses `done` to the owner.
- Transitions:
  - IDLE → ACCESS: any `pN_req`=1 at the clock edge. The winner's `we`, `addr` and `wdata` and the owner id are latched.
  - IDLE → DONE: winner's `addr[1:0]`≠0. No strobes are driven, `err`=1, `rdata`=0.
  - ACCESS → DONE: counter reaches `LAT`. For reads, `mem_rdata` is captured into the owner's `rdata` register.
  - DONE → IDLE: unconditional. Requests are ignored while in DONE.
- Strobes:
  - `mem_read`=~we and `mem_write`=we, both only in ACCESS.
  - `mem_addr` and `mem_wdata` come from the latched request and hold their value outside ACCESS.
- Non-owner `done` and `err` stay 0. Each port's `rdata` holds its last captured value.
- Requester rule: drop `req` no later than the cycle after `done` (registered). If `req` is still high in the following IDLE, it is a new transaction.
- `req` deasserted mid-transaction: the latched transaction still completes and `done` is still pulsed.
- Request inputs changing after the latch have no effect on the transaction in progress.
- Default arbitration (macro absent): fixed priority, port 0 wins. Port 1 can starve under continuous port 0 traffic; this is accepted.

## Timing
- Reset values:
  - state IDLE; counter 0.
  - `mem_read`, `mem_write`, `mem_addr`, `mem_wdata` = 0.
  - All `pN_done`, `pN_err`, `pN_rdata` = 0.
  - Round-robin pointer = "port 1 last".
- Latency: `req` first high in cycle 0 → ACCESS in cycles 1..`LAT` → `done` in cycle `LAT`+1.
  - Misaligned access: `done` and `err` in cycle 1.
- Throughput: one transaction per `LAT`+2 cycles. The next IDLE is at `LAT`+2.
- Simultaneous requests: resolved in the IDLE cycle by the arbitration rule. The loser remains pending and is granted at the next IDLE, cycle `LAT`+2.
- Asynchronous reset mid-ACCESS or mid-DONE:
  - Strobes and `done` drop immediately.
  - The transaction is discarded and no `done` is issued.
  - The memory may have already performed the write.
- The counter is ceil(log2(`LAT`+1)) bits and is cleared on entry to ACCESS.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin arbitration.
  - A 1-bit pointer records the last granted port and is updated on each grant, including misaligned ones.
  - On simultaneous requests, the port not granted last wins.
  - The first contested grant after reset goes to port 0.
- `DMEM_ARB_RR_EN` undefined: the pointer logic is absent and fixed priority applies (port 0 wins).

## Test plan
- Port 0 read, `addr`=0x10, `LAT`=2, memory word 4 = 0x4 → `mem_read` high in cycles 1–2, `mem_addr`=0x10; `p0_done`=1, `p0_rdata`=0x4, `p0_err`=0 in cycle 3.
- Port 1 write, `addr`=0x20, `wdata`=0xDEAD → `mem_write` high in cycles 1–2; port 1 read of 0x20 afterward returns 0xDEAD.
- Both ports request a read in cycle 0:
  - Fixed priority: `p0_done` in cycle 3, `p1_done` in cycle 7.
  - With `DMEM_ARB_RR_EN`, a second simultaneous pair: the winner alternates (0, 1, 0, 1…).
- Port 0 `addr`=0x13 → no strobe asserted; `p0_done`=1, `p0_err`=1, `p0_rdata`=0 in cycle 1.
- `rst_n` pulsed low in cycle 1 of a port 0 read → strobes 0 immediately, state IDLE, no `p0_done`, all outputs at reset values.
- Port 0 drops `req` in cycle 1 of a read → `p0_done` still in cycle 3 with valid `rdata`; no second transaction follows.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Two-port arbiter and access sequencer in front of a single-ported data
//   memory. Port 0 is the pipeline MEM stage and port 1 is a secondary master
//   such as a loader or debug port. One request is latched at a time. The
//   memory strobes are held for LAT cycles, read data is captured on the last
//   of those cycles, and the owner gets a one-cycle done pulse. Misaligned
//   word accesses complete immediately with err set and never touch memory.
//
//   Build option: define DMEM_ARB_RR_EN for round-robin arbitration between
//   the two ports. Without it, port 0 has fixed priority over port 1.
//
// Ports
//   clk, rst_n                  clock (rising edge), async active-low reset
//   pN_req/we/addr/wdata        request from port N (req held until done)
//   pN_done/rdata/err           completion pulse, read data, misalign flag
//   mem_addr/wdata/read/write   memory-side request (byte address)
//   mem_rdata                   memory read data
module dmem_arbiter #(
  parameter int unsigned AW  = 32,
  parameter int unsigned DW  = 32,
  parameter int unsigned LAT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_done,
  output logic [DW-1:0] p0_rdata,
  output logic          p0_err,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_done,
  output logic [DW-1:0] p1_rdata,
  output logic          p1_err,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_read,
  output logic          mem_write,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned      CW    = $clog2(LAT + 1);
  localparam logic [CW-1:0]    LAT_C = CW'(LAT);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic          access_last;

  logic          any_req;
  logic          grant_id;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          misaligned;

  logic          lat_we;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;
  logic          owner;
  logic          err_flag;

  // Arbitration
  always_comb any_req = p0_req | p1_req;

`ifdef DMEM_ARB_RR_EN
  // Pointer to the last granted port; reset value says "port 1 last" so the
  // first contested grant goes to port 0.
  logic last_grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (state == IDLE && any_req) begin
      last_grant <= grant_id;
    end
  end

  always_comb begin
    if (p0_req && p1_req) grant_id = ~last_grant;
    else                  grant_id = p1_req;
  end
`else
  // Port 1 only wins when port 0 is not asking.
  always_comb grant_id = ~p0_req;
`endif

  always_comb begin
    sel_we     = grant_id ? p1_we    : p0_we;
    sel_addr   = grant_id ? p1_addr  : p0_addr;
    sel_wdata  = grant_id ? p1_wdata : p0_wdata;
    misaligned = (sel_addr[1:0] != 2'b00);
    cnt_inc    = cnt + CW'(1);
    access_last = (cnt_inc == LAT_C);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next state and outputs. Strobes and done decode straight from the state
  // register so an async reset drops them immediately.
  always_comb begin
    state_next = state;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    p0_done    = 1'b0;
    p1_done    = 1'b0;
    p0_err     = 1'b0;
    p1_err     = 1'b0;
    mem_addr   = lat_addr;
    mem_wdata  = lat_wdata;
    case (state)
      IDLE: begin
        if (any_req) state_next = misaligned ? DONE : ACCESS;
      end
      ACCESS: begin
        mem_read  = ~lat_we;
        mem_write = lat_we;
        if (access_last) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
        p0_done    = ~owner;
        p1_done    = owner;
        p0_err     = ~owner & err_flag;
        p1_err     = owner & err_flag;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request latch, access counter and per-port read data. A misaligned grant
  // records owner/err only, so mem_addr/mem_wdata keep the last real access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      owner     <= 1'b0;
      err_flag  <= 1'b0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner    <= grant_id;
            err_flag <= misaligned;
            cnt      <= '0;
            if (misaligned) begin
              if (grant_id) p1_rdata <= '0;
              else          p0_rdata <= '0;
            end else begin
              lat_we    <= sel_we;
              lat_addr  <= sel_addr;
              lat_wdata <= sel_wdata;
            end
          end
        end
        ACCESS: begin
          cnt <= cnt_inc;
          if (access_last && !lat_we) begin
            if (owner) p1_rdata <= mem_rdata;
            else       p0_rdata <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Self-checking bench for dmem_arbiter: table of directed transactions,
//   randomized single transactions against a reference memory, and
//   hand-written contention, reset and early-drop sequences.
module tb_dmem_arbiter;

  localparam int unsigned LAT = 2;

  logic        clk;
  logic        rst_n;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_done, p0_err, p1_done, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];

  dmem_arbiter #(.AW(32), .DW(32), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_done(p0_done), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_done(p1_done), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory behind the arbiter: combinational read, write on the clock edge.
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic drive(input int port, input logic req, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (port == 0) begin
      p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata;
    end else begin
      p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata;
    end
  endtask

  // One transaction on one port. Cycle 0 is the cycle req is first high.
  task automatic do_txn(input int port, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rd,
                        output logic er, output int lat, output int first,
                        output int rdc, output int wrc, output int bad);
    logic own_done, oth_done;
    rd = '0; er = 1'b0; lat = -1; first = -1; rdc = 0; wrc = 0; bad = 0;
    @(posedge clk); #1;
    drive(port, 1'b1, we, addr, wdata);
    for (int n = 1; n <= 20 && lat < 0; n++) begin
      @(posedge clk); #1;
      // Scramble the request payload once it has been latched.
      if (n == 1) drive(port, 1'b1, ~we, ~addr, ~wdata);
      own_done = (port == 0) ? p0_done : p1_done;
      oth_done = (port == 0) ? p1_done : p0_done;
      if (mem_read)  rdc++;
      if (mem_write) wrc++;
      if ((mem_read || mem_write) && first < 0) first = n;
      if ((mem_read || mem_write) && mem_addr !== addr) bad++;
      if (mem_write && mem_wdata !== wdata) bad++;
      if (oth_done) bad++;
      if (own_done) begin
        lat = n;
        rd  = (port == 0) ? p0_rdata : p1_rdata;
        er  = (port == 0) ? p0_err : p1_err;
        drive(port, 1'b0, 1'b0, '0, '0);
      end
    end
    if (lat < 0) drive(port, 1'b0, 1'b0, '0, '0);
    @(posedge clk); #1;
    if (p0_done || p1_done || mem_read || mem_write) bad++;
  endtask

  task automatic run_vec(input string tag, input int port, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err);
    logic [31:0] rd;
    logic        er;
    int          lat, first, rdc, wrc, bad;
    do_txn(port, we, addr, wdata, rd, er, lat, first, rdc, wrc, bad);
    check({tag, ".latency"}, 32'(lat), exp_err ? 32'd1 : 32'(LAT + 1));
    check({tag, ".err"}, {31'b0, er}, {31'b0, exp_err});
    if (!we) check({tag, ".rdata"}, rd, exp_rdata);
    check({tag, ".read_cycles"}, 32'(rdc), (!we && !exp_err) ? 32'(LAT) : 32'd0);
    check({tag, ".write_cycles"}, 32'(wrc), (we && !exp_err) ? 32'(LAT) : 32'd0);
    if (!exp_err) check({tag, ".first_strobe"}, 32'(first), 32'd1);
    check({tag, ".side_effects"}, 32'(bad), 32'd0);
    if (we && !exp_err) ref_mem[addr[9:2]] = wdata;
  endtask

  typedef struct {
    int          port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vt [9];

  initial begin
    int d0, d1, k, quiet;
    int dport [4];
    int dcyc  [4];
    logic [31:0] r1;
    logic [31:0] rdv;

    for (int i = 0; i < 256; i++) begin
      mem[i]     = 32'(i);
      ref_mem[i] = 32'(i);
    end
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);

    // Reset values
    #12;
    check("reset.p0_done", {31'b0, p0_done}, 32'd0);
    check("reset.p1_done", {31'b0, p1_done}, 32'd0);
    check("reset.p0_err", {31'b0, p0_err}, 32'd0);
    check("reset.p1_err", {31'b0, p1_err}, 32'd0);
    check("reset.p0_rdata", p0_rdata, 32'd0);
    check("reset.p1_rdata", p1_rdata, 32'd0);
    check("reset.mem_read", {31'b0, mem_read}, 32'd0);
    check("reset.mem_write", {31'b0, mem_write}, 32'd0);
    check("reset.mem_addr", mem_addr, 32'd0);
    check("reset.mem_wdata", mem_wdata, 32'd0);
    #10 rst_n = 1'b1;

    // Directed table
    vt[0] = '{0, 1'b0, 32'h10,  32'h0,        32'h4,        1'b0};
    vt[1] = '{1, 1'b1, 32'h20,  32'hDEAD,     32'h0,        1'b0};
    vt[2] = '{1, 1'b0, 32'h20,  32'h0,        32'hDEAD,     1'b0};
    vt[3] = '{0, 1'b0, 32'h13,  32'h0,        32'h0,        1'b1};
    vt[4] = '{1, 1'b0, 32'h02,  32'h0,        32'h0,        1'b1};
    vt[5] = '{0, 1'b1, 32'h3FC, 32'h12345678, 32'h0,        1'b0};
    vt[6] = '{0, 1'b0, 32'h3FC, 32'h0,        32'h12345678, 1'b0};
    vt[7] = '{1, 1'b0, 32'h0,   32'h0,        32'h0,        1'b0};
    vt[8] = '{0, 1'b0, 32'h11,  32'h0,        32'h0,        1'b1};
    for (int i = 0; i < 9; i++)
      run_vec($sformatf("vec%0d", i), vt[i].port, vt[i].we, vt[i].addr,
              vt[i].wdata, vt[i].exp_rdata, vt[i].exp_err);

    // Randomized single transactions against the reference memory
    for (int i = 0; i < 40; i++) begin
      int          port;
      logic        we, er;
      logic [7:0]  idx;
      logic [1:0]  mis;
      logic [31:0] addr, wdata, er_data;
      port  = int'($urandom_range(0, 1));
      we    = 1'($urandom_range(0, 1));
      idx   = 8'($urandom_range(0, 255));
      mis   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      addr  = {22'b0, idx, mis};
      wdata = $urandom;
      er    = (mis != 2'b00);
      er_data = er ? 32'h0 : ref_mem[idx];
      repeat ($urandom_range(0, 3)) @(posedge clk);
      run_vec($sformatf("rand%0d", i), port, we, addr, wdata, er_data, er);
    end

    // Return to reset state (arbitration pointer included)
    @(posedge clk); #3 rst_n = 1'b0; #3 rst_n = 1'b1;

    // Simultaneous reads: port 0 first, port 1 at the next IDLE
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 32'h10, '0);
    drive(1, 1'b1, 1'b0, 32'h14, '0);
    d0 = -1; d1 = -1; r1 = '0; quiet = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (p0_done && p1_done) quiet++;
      if (p0_done && d0 < 0) begin d0 = n; p0_req = 1'b0; end
      if (p1_done && d1 < 0) begin d1 = n; r1 = p1_rdata; p1_req = 1'b0; end
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    check("pair.p0_done_cycle", 32'(d0), 32'(LAT + 1));
    check("pair.p1_done_cycle", 32'(d1), 32'(2 * LAT + 3));
    check("pair.p1_rdata", r1, ref_mem[5]);
    check("pair.overlap", 32'(quiet), 32'd0);

    // Continuous contention: both ports keep req high for four grants
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 32'h10, '0);
    drive(1, 1'b1, 1'b0, 32'h14, '0);
    for (int j = 0; j < 4; j++) begin dport[j] = -1; dcyc[j] = -1; end
    k = 0; quiet = 0;
    for (int n = 1; n <= 60 && k < 4; n++) begin
      @(posedge clk); #1;
      if (p0_done && p1_done) quiet++;
      else if (p0_done) begin dport[k] = 0; dcyc[k] = n; k++; end
      else if (p1_done) begin dport[k] = 1; dcyc[k] = n; k++; end
      if (k == 4) begin p0_req = 1'b0; p1_req = 1'b0; end
    end
    p0_req = 1'b0; p1_req = 1'b0;
    for (int j = 0; j < 4; j++) begin
`ifdef DMEM_ARB_RR_EN
      check($sformatf("stream%0d.port", j), 32'(dport[j]), 32'(j % 2));
`else
      check($sformatf("stream%0d.port", j), 32'(dport[j]), 32'd0);
`endif
      check($sformatf("stream%0d.cycle", j), 32'(dcyc[j]), 32'((j + 1) * (LAT + 2) - 1));
    end
    repeat (4) begin
      @(posedge clk); #1;
      if (p0_done || p1_done || mem_read || mem_write) quiet++;
    end
    check("stream.quiet_after", 32'(quiet), 32'd0);

    // Async reset in cycle 1 of a port 0 read
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 32'h10, '0);
    @(posedge clk); #1;
    check("rst_mid.mem_read_before", {31'b0, mem_read}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid.mem_read", {31'b0, mem_read}, 32'd0);
    check("rst_mid.mem_write", {31'b0, mem_write}, 32'd0);
    check("rst_mid.mem_addr", mem_addr, 32'd0);
    check("rst_mid.p0_done", {31'b0, p0_done}, 32'd0);
    check("rst_mid.p0_rdata", p0_rdata, 32'd0);
    p0_req = 1'b0;
    #3 rst_n = 1'b1;
    quiet = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (p0_done || p1_done || mem_read || mem_write) quiet++;
    end
    check("rst_mid.no_done", 32'(quiet), 32'd0);

    // Port 0 drops req in cycle 1 of a read
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 32'h18, '0);
    d0 = -1; k = 0; quiet = 0; rdv = '0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      if (n == 1) p0_req = 1'b0;
      if (mem_read) quiet++;
      if (p0_done) begin k++; if (d0 < 0) begin d0 = n; rdv = p0_rdata; end end
    end
    check("drop.done_cycle", 32'(d0), 32'(LAT + 1));
    check("drop.rdata", rdv, ref_mem[6]);
    check("drop.done_count", 32'(k), 32'd1);
    check("drop.read_cycles", 32'(quiet), 32'(LAT));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
